// File: rtl/mem_pkg.sv
// Shared types, func3 encodings and lane helpers for the MEM-stage load/store unit.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Loads always fetch the whole word; lane selection happens on the way back.
    function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] off,
                                           input logic is_store);
        logic [3:0] be;
        be = 4'b1111;
        if (is_store) begin
            case (f3)
                F3_B:    be = 4'b0001 << off;
                F3_H:    be = 4'b0011 << off;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    // func3[1:0] gives the access size for both signed and unsigned variants.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Lane select and sign/zero extension of a captured read word for the MEM/WB register.
module load_formatter
    import mem_pkg::*;
#(
    parameter int unsigned data_bits = 32
) (
    input  logic [data_bits-1:0] i_rdata,
    input  logic [1:0]           i_off,
    input  logic [2:0]           i_f3,
    output logic [data_bits-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_off, 3'b000} +: 8];
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_f3)
            F3_B:    o_data = {{(data_bits - 8){w_byte[7]}}, w_byte};
            F3_BU:   o_data = {{(data_bits - 8){1'b0}}, w_byte};
            F3_H:    o_data = {{(data_bits - 16){w_half[15]}}, w_half};
            F3_HU:   o_data = {{(data_bits - 16){1'b0}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ready data-memory master with pipeline stall.
// Define LSU_TIMEOUT_EN to abort a request that sees no dmem_ready within timeout_cycles.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int unsigned data_bits      = 32,
    parameter int unsigned timeout_cycles = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read_in,
    input  logic                 mem_write_in,
    input  logic [data_bits-1:0] addr_in,
    input  logic [data_bits-1:0] store_data_in,
    input  logic [2:0]           func_3_bits_in,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [data_bits-1:0] dmem_addr,
    output logic [3:0]           dmem_be,
    output logic [data_bits-1:0] dmem_wdata,
    input  logic                 dmem_ready,
    input  logic [data_bits-1:0] dmem_rdata,
    output logic [data_bits-1:0] load_data_out,
    output logic                 load_valid_out,
    output logic                 stall_out,
    output logic                 fault_out,
    output logic [data_bits-1:0] fault_addr_out
);

    lsu_state_t           r_state;
    logic                 r_we;
    logic [data_bits-1:0] r_addr;
    logic [3:0]           r_be;
    logic [data_bits-1:0] r_wdata;
    logic [2:0]           r_f3;
    logic [data_bits-1:0] r_rdata;
    logic [1:0]           r_ld_off;
    logic [2:0]           r_ld_f3;
    logic                 r_load_valid;
    logic                 r_fault;
    logic [data_bits-1:0] r_fault_addr;

    logic                 w_access;
    logic                 w_bad_f3;
    logic                 w_illegal;
    logic [data_bits-1:0] w_wdata;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned cnt_bits = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [cnt_bits-1:0] cnt_last = cnt_bits'(timeout_cycles - 1);
    logic [cnt_bits-1:0] r_cnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (timeout_cycles != 0);
`endif

    assign w_access = mem_read_in | mem_write_in;

    always_comb begin
        case (func_3_bits_in)
            F3_B, F3_H, F3_W: w_bad_f3 = 1'b0;
            F3_BU, F3_HU:     w_bad_f3 = mem_write_in;
            default:          w_bad_f3 = 1'b1;
        endcase
        w_illegal = (mem_read_in & mem_write_in) | w_bad_f3 |
                    is_misaligned(func_3_bits_in, addr_in[1:0]);
    end

    always_comb begin
        case (func_3_bits_in)
            F3_B:    w_wdata = {(data_bits / 8){store_data_in[7:0]}};
            F3_H:    w_wdata = {(data_bits / 16){store_data_in[15:0]}};
            default: w_wdata = store_data_in;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_f3         <= '0;
            r_rdata      <= '0;
            r_ld_off     <= '0;
            r_ld_f3      <= '0;
            r_load_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
`ifdef LSU_TIMEOUT_EN
            r_cnt        <= '0;
`endif
        end else begin
            r_load_valid <= 1'b0;
            r_fault      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_access && w_illegal) begin
                        r_fault      <= 1'b1;
                        r_fault_addr <= addr_in;
                    end else if (w_access) begin
                        r_state <= REQ;
                        r_we    <= mem_write_in;
                        r_addr  <= addr_in;
                        r_be    <= calc_be(func_3_bits_in, addr_in[1:0], mem_write_in);
                        r_wdata <= w_wdata;
                        r_f3    <= func_3_bits_in;
`ifdef LSU_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                REQ: begin
                    if (dmem_ready) begin
                        r_state <= RESP;
                        if (!r_we) begin
                            r_rdata      <= dmem_rdata;
                            r_ld_off     <= r_addr[1:0];
                            r_ld_f3      <= r_f3;
                            r_load_valid <= 1'b1;
                        end
`ifdef LSU_TIMEOUT_EN
                    end else if (r_cnt == cnt_last) begin
                        r_state      <= RESP;
                        r_fault      <= 1'b1;
                        r_fault_addr <= r_addr;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // The formatter sees only the last completed load, so load_data_out holds across stores.
    load_formatter #(
        .data_bits(data_bits)
    ) u_load_formatter (
        .i_rdata(r_rdata),
        .i_off  (r_ld_off),
        .i_f3   (r_ld_f3),
        .o_data (load_data_out)
    );

    assign dmem_req       = (r_state == REQ);
    assign dmem_we        = r_we;
    assign dmem_addr      = {r_addr[data_bits-1:2], 2'b00};
    assign dmem_be        = r_be;
    assign dmem_wdata     = r_wdata;
    assign load_valid_out = r_load_valid;
    assign fault_out      = r_fault;
    assign fault_addr_out = r_fault_addr;
    assign stall_out      = (r_state == REQ) ||
                            ((r_state == IDLE) && w_access && !w_illegal);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed-vector bench for mem_stage_lsu with hand-computed expectations.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst_n;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic [2:0]  func_3_bits_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data_out;
    logic        load_valid_out;
    logic        stall_out;
    logic        fault_out;
    logic [31:0] fault_addr_out;

    int n_vec = 0;
    int n_err = 0;

    mem_stage_lsu #(
        .data_bits     (32),
        .timeout_cycles(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .addr_in       (addr_in),
        .store_data_in (store_data_in),
        .func_3_bits_in(func_3_bits_in),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_ready    (dmem_ready),
        .dmem_rdata    (dmem_rdata),
        .load_data_out (load_data_out),
        .load_valid_out(load_valid_out),
        .stall_out     (stall_out),
        .fault_out     (fault_out),
        .fault_addr_out(fault_addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1 with the FSM in IDLE.
    task automatic legal_access(input string tag, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [2:0] f3, input int waits,
                                input logic [31:0] rdata, input logic [3:0] exp_be,
                                input logic [31:0] exp_wdata, input logic exp_lv,
                                input logic [31:0] exp_ld);
        mem_read_in    = rd;
        mem_write_in   = wr;
        addr_in        = addr;
        store_data_in  = sdata;
        func_3_bits_in = f3;
        dmem_ready     = 1'b0;
        @(negedge clk);
        check_eq({tag, " c0 stall"}, 32'(stall_out), 32'd1);
        check_eq({tag, " c0 req"}, 32'(dmem_req), 32'd0);
        for (int i = 0; i <= waits; i++) begin
            @(posedge clk);
            #1;
            dmem_ready = (i == waits);
            dmem_rdata = (i == waits) ? rdata : 32'h5A5A5A5A;
            @(negedge clk);
            check_eq({tag, " req"}, 32'(dmem_req), 32'd1);
            check_eq({tag, " req stall"}, 32'(stall_out), 32'd1);
            if (i == 0 || i == waits) begin
                check_eq({tag, " addr"}, dmem_addr, {addr[31:2], 2'b00});
                check_eq({tag, " be"}, 32'(dmem_be), 32'(exp_be));
                check_eq({tag, " we"}, 32'(dmem_we), 32'(wr));
                if (wr) check_eq({tag, " wdata"}, dmem_wdata, exp_wdata);
            end
        end
        @(posedge clk);
        #1;
        dmem_ready = 1'b0;
        @(negedge clk);
        check_eq({tag, " resp req"}, 32'(dmem_req), 32'd0);
        check_eq({tag, " resp stall"}, 32'(stall_out), 32'd0);
        check_eq({tag, " valid"}, 32'(load_valid_out), 32'(exp_lv));
        check_eq({tag, " load_data"}, load_data_out, exp_ld);
        check_eq({tag, " resp fault"}, 32'(fault_out), 32'd0);
        @(posedge clk);
        #1;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        @(negedge clk);
        check_eq({tag, " idle valid"}, 32'(load_valid_out), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic illegal_access(input string tag, input logic rd, input logic wr,
                                  input logic [31:0] addr, input logic [2:0] f3);
        mem_read_in    = rd;
        mem_write_in   = wr;
        addr_in        = addr;
        store_data_in  = 32'h11223344;
        func_3_bits_in = f3;
        @(negedge clk);
        check_eq({tag, " stall"}, 32'(stall_out), 32'd0);
        check_eq({tag, " fault early"}, 32'(fault_out), 32'd0);
        @(posedge clk);
        #1;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        @(negedge clk);
        check_eq({tag, " fault"}, 32'(fault_out), 32'd1);
        check_eq({tag, " fault_addr"}, fault_addr_out, addr);
        check_eq({tag, " req"}, 32'(dmem_req), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq({tag, " fault clear"}, 32'(fault_out), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        mem_read_in    = 1'b0;
        mem_write_in   = 1'b0;
        addr_in        = '0;
        store_data_in  = '0;
        func_3_bits_in = '0;
        dmem_ready     = 1'b0;
        dmem_rdata     = '0;
        #3;
        check_eq("rst req", 32'(dmem_req), 32'd0);
        check_eq("rst stall", 32'(stall_out), 32'd0);
        check_eq("rst valid", 32'(load_valid_out), 32'd0);
        check_eq("rst fault", 32'(fault_out), 32'd0);
        check_eq("rst load_data", load_data_out, 32'd0);
        check_eq("rst fault_addr", fault_addr_out, 32'd0);
        check_eq("rst be", 32'(dmem_be), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        legal_access("LW", 1, 0, 32'h100, 0, 3'b010, 0, 32'hDEADBEEF, 4'b1111, 0, 1, 32'hDEADBEEF);
        legal_access("LB", 1, 0, 32'h103, 0, 3'b000, 0, 32'h80FF7F01, 4'b1111, 0, 1, 32'hFFFFFF80);
        legal_access("LBU", 1, 0, 32'h103, 0, 3'b100, 1, 32'h80FF7F01, 4'b1111, 0, 1, 32'h00000080);
        legal_access("SH", 0, 1, 32'h202, 32'h0000ABCD, 3'b001, 3, 32'h0, 4'b1100, 32'hABCDABCD,
                     0, 32'h00000080);
        legal_access("LH", 1, 0, 32'h102, 0, 3'b001, 0, 32'h80FF7F01, 4'b1111, 0, 1, 32'hFFFF80FF);
        legal_access("LHU", 1, 0, 32'h100, 0, 3'b101, 2, 32'h80FF7F01, 4'b1111, 0, 1, 32'h00007F01);
        legal_access("SB", 0, 1, 32'h201, 32'h12345678, 3'b000, 0, 32'h0, 4'b0010, 32'h78787878,
                     0, 32'h00007F01);
        legal_access("SW", 0, 1, 32'h204, 32'hCAFEF00D, 3'b010, 1, 32'h0, 4'b1111, 32'hCAFEF00D,
                     0, 32'h00007F01);

        illegal_access("LW mis", 1, 0, 32'h101, 3'b010);
        illegal_access("LH mis", 1, 0, 32'h103, 3'b001);
        illegal_access("SBU", 0, 1, 32'h200, 3'b100);
        illegal_access("F3 011", 1, 0, 32'h108, 3'b011);
        illegal_access("RD+WR", 1, 1, 32'h10C, 3'b010);

        // Reset while REQ is outstanding.
        mem_read_in    = 1'b1;
        addr_in        = 32'h300;
        func_3_bits_in = 3'b010;
        dmem_ready     = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rstmid req before", 32'(dmem_req), 32'd1);
        #2;
        rst_n       = 1'b0;
        mem_read_in = 1'b0;
        #1;
        check_eq("rstmid req drop", 32'(dmem_req), 32'd0);
        check_eq("rstmid stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rstmid valid", 32'(load_valid_out), 32'd0);
            check_eq("rstmid fault", 32'(fault_out), 32'd0);
            check_eq("rstmid req", 32'(dmem_req), 32'd0);
        end
        @(posedge clk);
        #1;
        legal_access("LW post", 1, 0, 32'h104, 0, 3'b010, 0, 32'h01234567, 4'b1111, 0, 1,
                     32'h01234567);

`ifdef LSU_TIMEOUT_EN
        begin
            int n_req;
            n_req          = 0;
            mem_read_in    = 1'b1;
            addr_in        = 32'h400;
            func_3_bits_in = 3'b010;
            dmem_ready     = 1'b0;
            @(posedge clk);
            #1;
            mem_read_in = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (!dmem_req) break;
                n_req++;
                @(posedge clk);
                #1;
            end
            check_eq("tmo req cycles", 32'(n_req), 32'd16);
            check_eq("tmo fault", 32'(fault_out), 32'd1);
            check_eq("tmo fault_addr", fault_addr_out, 32'h400);
            check_eq("tmo valid", 32'(load_valid_out), 32'd0);
            check_eq("tmo stall", 32'(stall_out), 32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            check_eq("tmo idle fault", 32'(fault_out), 32'd0);
            check_eq("tmo idle req", 32'(dmem_req), 32'd0);
            @(posedge clk);
            #1;
        end
`else
        // Without the timeout the request simply waits for memory.
        legal_access("LW slow", 1, 0, 32'h400, 0, 3'b010, 20, 32'h0BADF00D, 4'b1111, 0, 1,
                     32'h0BADF00D);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit of the MEM stage. Sits directly downstream of the EX/MEM pipeline register and consumes its address (ALU result), store data (read data 2), func3 and control.
- Drives a single-port data memory through a req/ready handshake and formats load data (byte/half/word, sign/zero extension) for the MEM/WB register.
- Stalls the pipeline while an access is outstanding.

Parameters:
- data_bits, 32, data and address width; only 32 is supported.
- timeout_cycles, 16, maximum REQ cycles before abort; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read_in  in  1  load request from EX/MEM
- mem_write_in  in  1  store request from EX/MEM
- addr_in  in  data_bits  byte address (EX/MEM alu_result_out)
- store_data_in  in  data_bits  EX/MEM alu_read_data_2_out
- func_3_bits_in  in  3  access size/sign
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  data_bits  word-aligned address, addr_in with [1:0]=0
- dmem_be  out  4  byte enables
- dmem_wdata  out  data_bits  lane-replicated store data
- dmem_ready  in  1  memory accepted/completed this cycle
- dmem_rdata  in  data_bits  read word, valid when dmem_ready
- load_data_out  out  data_bits  formatted load result
- load_valid_out  out  1  one-cycle pulse, load_data_out valid
- stall_out  out  1  freeze upstream registers
- fault_out  out  1  one-cycle pulse, misaligned or illegal access
- fault_addr_out  out  data_bits  address of the faulting access

Behaviour:
- Reset: all outputs 0; state IDLE. Reset asserted mid-access drops dmem_req immediately. The in-flight access is discarded; no valid or fault pulse is generated.
- FSM states:
  - IDLE: inputs are sampled only in IDLE. An access is mem_read_in | mem_write_in.
    - No access: stay IDLE, stall_out=0.
    - Legal access: stall_out=1 combinationally; register the request; go to REQ.
    - Illegal access: fault_out and fault_addr_out are registered (pulse next cycle); no request is issued; stall_out=0; stay IDLE.
  - REQ: dmem_req=1; dmem_we, dmem_addr, dmem_be and dmem_wdata held stable; stall_out=1.
    - dmem_ready=1: capture dmem_rdata (loads) and go to RESP.
    - dmem_ready=0: stay in REQ.
  - RESP: stall_out=0; dmem_req=0. For a load, load_valid_out=1 and load_data_out is the formatted data. Next state is IDLE. The upstream register advances at the end of RESP, so the next access is evaluated in IDLE.
- Minimum latency: access seen in cycle 0, dmem_req in cycle 1, load_valid_out in cycle 2. stall_out is high for cycles 0..(ready cycle).
- load_data_out holds its value until the next load completes.
- func3 encodings:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - 100/101 on a store, and 011/110/111 on any access, are illegal.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- mem_read_in and mem_write_in both high: illegal.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: be = 0011 << addr[1:0]; wdata = half replicated x2.
  - SW: be = 1111.
  - Loads drive be = 1111.
- Load formatting: select the byte/half by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- dmem_ready outside REQ is ignored.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: a counter starts at 0 on entry to REQ and increments each REQ cycle. When it reaches timeout_cycles-1 with dmem_ready=0:
  - drop dmem_req;
  - pulse fault_out with fault_addr_out=addr;
  - go to RESP with load_valid_out=0.
  - dmem_ready in that same cycle takes precedence (normal completion).
- Undefined: no counter; REQ waits indefinitely.

Decomposition:
- Shared package mem_pkg holds:
  - lsu_state_t enum (IDLE, REQ, RESP);
  - func3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - functions calc_be() and is_misaligned().
- One natural sub-module, load_formatter: combinational lane select plus sign/zero extension, instantiated on the captured read word.

Test Plan:
- LW addr 0x100, dmem_ready in first REQ cycle, rdata 0xDEADBEEF -> dmem_addr 0x100, be 1111; load_valid_out in cycle 2 with 0xDEADBEEF; stall_out high for cycles 0-1.
- LB addr 0x103 and LBU addr 0x103, rdata 0x80FF7F01 -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
- SH addr 0x202, data 0x0000ABCD, dmem_ready after 3 wait cycles -> be 1100, wdata 0xABCDABCD, dmem_we=1; stall_out held for 4 REQ cycles; no load_valid_out.
- LW addr 0x101 -> no dmem_req; fault_out pulse with fault_addr_out 0x101; stall_out=0.
- rst_n low during REQ -> dmem_req=0 immediately; no valid or fault pulse; after release, a new LW completes normally.
- LSU_TIMEOUT_EN, timeout_cycles=16, dmem_ready tied 0 -> fault_out after 16 REQ cycles; FSM returns to IDLE via RESP.
